// File: rtl/tdm_pkg.sv
// tdm_pkg: shared types and sizes for the 1:4 TDM demultiplexer
package tdm_pkg;
  typedef enum logic {HUNT = 1'b0, LOCK = 1'b1} state_t;
  localparam int NSLOT = 4;
  localparam int SLOT_W = 2;
  localparam int MISS_W = 3;
endpackage

// File: rtl/tdm_sync_fsm.sv
// tdm_sync_fsm: frame-sync lock tracking, slot counter and shadow write strobes
module tdm_sync_fsm
  import tdm_pkg::*;
#(
  parameter int SYNC_LOSS_MAX = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              din_valid,
  input  logic              fsync,
  output logic [SLOT_W-1:0] s,
  output logic              locked,
  output logic              sync_err,
  output logic [NSLOT-2:0]  wr,
  output logic              done
);
  state_t state, state_nx;
  logic [SLOT_W-1:0] s_nx;
  logic [MISS_W-1:0] miss_cnt, miss_nx, miss_inc;
  logic err_nx, missing, drop;
  assign miss_inc = miss_cnt + MISS_W'(1);
  assign missing = state == LOCK && s == '0 && !fsync;
  assign drop = missing && miss_inc == MISS_W'(SYNC_LOSS_MAX);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= HUNT;
      s <= '0;
      miss_cnt <= '0;
      sync_err <= 1'b0;
    end else begin
      state <= state_nx;
      s <= s_nx;
      miss_cnt <= miss_nx;
      sync_err <= err_nx;
    end
  end
  always_comb begin
    state_nx = state;
    s_nx = s;
    miss_nx = miss_cnt;
    err_nx = 1'b0;
    if (din_valid) begin
      if (state == HUNT) begin
        state_nx = fsync ? LOCK : HUNT;
        s_nx = fsync ? SLOT_W'(1) : '0;
        miss_nx = fsync ? '0 : miss_cnt;
      end else if (s == '0) begin
        err_nx = !fsync;
        miss_nx = fsync ? '0 : miss_inc;
        state_nx = drop ? HUNT : LOCK;
        s_nx = drop ? '0 : SLOT_W'(1);
      end else begin
        err_nx = fsync;
        s_nx = fsync ? SLOT_W'(1) : s + SLOT_W'(1);
      end
    end
  end
  // Any fsync realigns to slot 0; otherwise the current slot is written unless lock is being dropped.
  always_comb begin
    locked = state == LOCK;
    wr = '0;
    if (din_valid && (fsync || (state == LOCK && !drop)))
      wr = (NSLOT-1)'(1) << (fsync ? '0 : s);
    done = din_valid && state == LOCK && s == SLOT_W'(NSLOT - 1) && !fsync;
  end
endmodule

// File: rtl/tdm_demux_1to4.sv
// tdm_demux_1to4: 1:4 TDM slot demultiplexer publishing whole frames with a valid strobe
module tdm_demux_1to4
  import tdm_pkg::*;
#(
  parameter int WIDTH = 1,
  parameter int SYNC_LOSS_MAX = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [WIDTH-1:0]   din,
  input  logic               din_valid,
  input  logic               fsync,
  output logic [4*WIDTH-1:0] y,
  output logic               y_valid,
  output logic [1:0]         s,
  output logic               locked,
  output logic               sync_err
);
  logic [NSLOT-2:0] wr;
  logic done;
  logic [NSLOT-2:0][WIDTH-1:0] shadow;
  tdm_sync_fsm #(.SYNC_LOSS_MAX(SYNC_LOSS_MAX)) u_fsm (
    .clk(clk),
    .rst_n(rst_n),
    .din_valid(din_valid),
    .fsync(fsync),
    .s(s),
    .locked(locked),
    .sync_err(sync_err),
    .wr(wr),
    .done(done)
  );
  // Slot 3 bypasses the shadow and lands straight in y with the buffered slots.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow <= '0;
      y <= '0;
      y_valid <= 1'b0;
    end else begin
      y_valid <= done;
      if (done) y <= {din, shadow[2], shadow[1], shadow[0]};
      for (int i = 0; i < NSLOT - 1; i++)
        if (wr[i]) shadow[i] <= din;
    end
  end
endmodule
